// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, RUN/WAIT/HALT fetch FSM, one-entry hold buffer
// for stalled deliveries, and a pending redirect target for redirects taken mid-miss.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_fetch,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        mem_done,
  output logic [15:0] instruction,
  output logic [15:0] incremented_pc,
  output logic        flush_fetch,
  output logic        inst_stall,
  output logic        inst_mis_align,
  output logic        halted
);

  typedef enum logic [1:0] {StRun, StWait, StHalt} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        hold_valid_q, hold_valid_d;
  logic [15:0] hold_data_q, hold_data_d;
  logic        pend_valid_q, pend_valid_d;
  logic [15:0] pend_pc_q, pend_pc_d;
  logic        halt_pend_q, halt_pend_d;

  assign mem_addr       = pc_q;
  assign incremented_pc = pc_q + 16'd2;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    hold_valid_d   = hold_valid_q;
    hold_data_d    = hold_data_q;
    pend_valid_d   = pend_valid_q;
    pend_pc_d      = pend_pc_q;
    halt_pend_d    = halt_pend_q;
    mem_rd         = 1'b0;
    instruction    = NOP_INST;
    flush_fetch    = 1'b0;
    inst_stall     = 1'b0;
    inst_mis_align = 1'b0;
    halted         = 1'b0;

    unique case (state_q)
      StRun: begin
        if (hold_valid_q) begin
          instruction = hold_data_q;
          if (redirect) begin
            flush_fetch  = 1'b1;
            pc_d         = redirect_pc;
            hold_valid_d = 1'b0;
          end else if (!stall_fetch) begin
            pc_d         = pc_q + 16'd2;
            hold_valid_d = 1'b0;
          end
        end else if (pc_q[0]) begin
          inst_mis_align = 1'b1;
          if (redirect) pc_d = redirect_pc;
        end else begin
          mem_rd     = 1'b1;
          inst_stall = !mem_done;
          if (mem_done) instruction = mem_data;
          if (redirect) begin
            flush_fetch = 1'b1;
            pc_d        = redirect_pc;
          end else if (!mem_done) begin
            state_d = StWait;
          end else if (stall_fetch) begin
            hold_valid_d = 1'b1;
            hold_data_d  = mem_data;
          end else begin
            pc_d = pc_q + 16'd2;
          end
        end
        if (halt && !redirect) state_d = StHalt;
      end

      StWait: begin
        mem_rd     = 1'b1;
        inst_stall = !mem_done;
        if (!mem_done) begin
          // Latest redirect wins and cancels any earlier deferred halt.
          if (redirect) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = redirect_pc;
            halt_pend_d  = 1'b0;
          end else if (halt) begin
            halt_pend_d = 1'b1;
          end
        end else begin
          state_d      = StRun;
          pend_valid_d = 1'b0;
          halt_pend_d  = 1'b0;
          if (redirect || pend_valid_q) begin
            flush_fetch = 1'b1;
            pc_d        = redirect ? redirect_pc : pend_pc_q;
          end else if (halt || halt_pend_q) begin
            flush_fetch = 1'b1;
            state_d     = StHalt;
          end else begin
            instruction = mem_data;
            if (stall_fetch) begin
              hold_valid_d = 1'b1;
              hold_data_d  = mem_data;
            end else begin
              pc_d = pc_q + 16'd2;
            end
          end
        end
      end

      StHalt: halted = 1'b1;

      default: state_d = StRun;
    endcase

    // Outputs are quiet for the whole time reset is held, not just after the edge.
    if (rst) begin
      mem_rd         = 1'b0;
      instruction    = NOP_INST;
      flush_fetch    = 1'b0;
      inst_stall     = 1'b0;
      inst_mis_align = 1'b0;
      halted         = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StRun;
      pc_q         <= RESET_PC;
      hold_valid_q <= 1'b0;
      hold_data_q  <= 16'h0000;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 16'h0000;
      halt_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      halt_pend_q  <= halt_pend_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Parameter NOP_INST, default 16'h0800, instruction word presented whenever no valid fetch is delivered.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 stall_fetch  input  1  downstream IF/ID register is holding; PC shall not advance.
REQ-006 redirect  input  1  taken branch, jump or exception; load redirect_pc.
REQ-007 redirect_pc  input  16  target address.
REQ-008 halt  input  1  HALT decoded downstream; stop fetching.
REQ-009 mem_rd  output  1  instruction memory read request.
REQ-010 mem_addr  output  16  read address, equal to current PC.
REQ-011 mem_data  input  16  read data, valid when mem_done=1.
REQ-012 mem_done  input  1  read complete this cycle.
REQ-013 instruction  output  16  fetched word toward IF/ID.
REQ-014 incremented_pc  output  16  PC+2 of the delivered instruction.
REQ-015 flush_fetch  output  1  delivered word is wrong-path; IF/ID shall insert NOP.
REQ-016 inst_stall  output  1  fetch outstanding; no valid instruction this cycle.
REQ-017 inst_mis_align  output  1  PC[0]=1; no read issued.
REQ-018 halted  output  1  fetch unit in HALT state.

Function
REQ-019 FSM states are RUN, WAIT and HALT; the reset state is RUN.
REQ-020 In RUN with PC[0]=0 and no valid hold buffer, mem_rd shall be 1 and mem_addr shall equal PC.
REQ-021 In RUN, mem_done=1 shall deliver mem_data with inst_stall=0, and PC shall become PC+2 at the next edge unless stall_fetch=1.
REQ-022 In RUN, mem_done=0 shall set inst_stall=1, drive instruction=NOP_INST, hold PC, and enter WAIT.
REQ-023 In WAIT, mem_rd shall stay 1 at the same address until mem_done=1, then behave as REQ-021 and return to RUN.
REQ-024 If mem_done=1 and stall_fetch=1 together, mem_data shall be captured in a one-entry hold buffer and PC held.
REQ-025 While the hold buffer is valid, the buffered word shall be presented with mem_rd=0; the buffer shall clear, and PC shall advance, on the first cycle with stall_fetch=0.
REQ-026 A redirect in RUN shall assert flush_fetch combinationally, load PC=redirect_pc at the next edge, and clear the hold buffer.
REQ-027 A redirect in WAIT shall record a pending target while mem_rd stays asserted.
REQ-028 When that read completes, its data shall be discarded with flush_fetch=1, PC shall load the pending target, and the FSM shall enter RUN.
REQ-029 A further redirect while a target is pending shall overwrite it.
REQ-030 PC[0]=1 in RUN shall force mem_rd=0, inst_mis_align=1 and instruction=NOP_INST, and PC shall hold until a redirect.
REQ-031 halt=1 shall enter HALT at the next edge, unless redirect=1 in the same cycle; redirect has priority.
REQ-032 HALT shall be exited only by rst.
REQ-033 In HALT, outputs shall be mem_rd=0, instruction=NOP_INST and halted=1.
REQ-034 halt=1 in WAIT shall defer entry to HALT until mem_done=1, and that data shall be discarded.
REQ-035 incremented_pc shall be PC+2 modulo 2^16; 16'hFFFE shall wrap to 16'h0000.

Reset
REQ-036 rst=1 shall immediately force PC=RESET_PC, state RUN, hold buffer empty, pending target cleared, and mem_rd=0.
REQ-037 rst=1 shall also force instruction=NOP_INST and flush_fetch, inst_stall, inst_mis_align and halted to 0.
REQ-038 Reset asserted mid-WAIT shall abandon the outstanding read.
REQ-039 Normal fetching shall resume on the first edge after rst deasserts.

Verification
REQ-040 Hits with mem_done=1 every cycle from reset -> mem_addr 0000, 0002, 0004; incremented_pc 0002, 0004, 0006.
REQ-041 Miss at 0010, mem_done delayed 3 cycles -> inst_stall=1 for 3 cycles; mem_addr stays 0010; data delivered on the 4th cycle; PC=0012 next.
REQ-042 mem_done=1 with stall_fetch=1 for 2 cycles at 0020 -> word held with mem_rd=0; PC advances to 0022 only after stall_fetch drops.
REQ-043 redirect to 0100 during a miss at 0030 -> on completion flush_fetch=1; next mem_addr=0100.
REQ-044 redirect_pc=0101 -> inst_mis_align=1, mem_rd=0, NOP_INST delivered; a later redirect to 0200 resumes fetching.
REQ-045 PC=FFFE -> incremented_pc=0000; halt with redirect same cycle -> not halted; halt alone -> halted=1 until rst.
